// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// stream_mux_pkg : shared mode encodings, channel-count limits and helpers
// Revision: 1.0
// ============================================================================
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int NUM_IN_MIN = 2;
   localparam int NUM_IN_MAX = 16;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// ============================================================================
// stream_mux_arb_if : N-channel input stream bundle plus single output stream
// Revision: 1.0
// ============================================================================
interface stream_mux_arb_if #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = $clog2(NUM_IN)
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [SEL_W-1:0]        sel;
   logic                    mode;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_src;

   modport master (
      output in_data, in_valid, sel, mode, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   modport slave (
      input  in_data, in_valid, sel, mode, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface
`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : picks the first requesting channel searching upward from ptr
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
   parameter int NUM_IN = 2,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  grant,
   output logic              grant_valid
);

   logic [2*NUM_IN-1:0] req_dbl;
   logic [2*NUM_IN-1:0] req_rot;
   logic [SEL_W:0]      idx_sum;

   // Rotating a doubled copy puts channel (ptr+k) mod NUM_IN at bit k.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl >> ptr;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx_sum     = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            idx_sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx_sum >= (SEL_W+1)'(NUM_IN)) begin
               idx_sum = idx_sum - (SEL_W+1)'(NUM_IN);
            end
            grant       = idx_sum[SEL_W-1:0];
            grant_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// stream_mux_arb : N-to-1 stream mux, fixed-select or round-robin, 1-deep out
// Build option: define STREAM_MUX_ARB_RR_EN to compile in round-robin mode.
// Revision: 1.0
// ============================================================================
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   stream_mux_arb_if.slave  bus
);

   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_src_q,   out_src_d;
   logic              out_valid_q, out_valid_d;

   logic              load_en;
   logic              fix_gv;
   logic              grant_valid;
   logic [SEL_W-1:0]  grant;
   logic [WIDTH-1:0]  grant_data;
   logic [NUM_IN-1:0] in_ready_w;

   assign load_en = !out_valid_q || bus.out_ready;

   always_comb begin
      fix_gv = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            fix_gv = bus.in_valid[i];
         end
      end
   end

`ifdef STREAM_MUX_ARB_RR_EN
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_gv;
   logic             use_rr;

   rr_arbiter #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_rr_arbiter (
      .req         (bus.in_valid),
      .ptr         (ptr_q),
      .grant       (rr_grant),
      .grant_valid (rr_gv)
   );

   assign use_rr      = (bus.mode == MODE_RR);
   assign grant       = use_rr ? rr_grant : bus.sel;
   assign grant_valid = use_rr ? rr_gv    : fix_gv;

   always_comb begin
      ptr_d = ptr_q;
      if (use_rr && load_en && grant_valid) begin
         ptr_d = SEL_W'(wrap_inc(int'(rr_grant), NUM_IN));
      end
   end
`else
   logic unused_mode;

   assign unused_mode = bus.mode;
   assign grant       = bus.sel;
   assign grant_valid = fix_gv;
`endif

   always_comb begin
      grant_data = '0;
      in_ready_w = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant == SEL_W'(i)) begin
            grant_data    = bus.in_data[i*WIDTH +: WIDTH];
            in_ready_w[i] = Reset_n && load_en && grant_valid && bus.in_valid[i];
         end
      end
   end

   // With no grant the stage empties, but data/src keep their last value.
   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      if (load_en) begin
         out_valid_d = grant_valid;
         if (grant_valid) begin
            out_data_d = grant_data;
            out_src_d  = grant;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
`ifdef STREAM_MUX_ARB_RR_EN
         ptr_q       <= '0;
`endif
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
`ifdef STREAM_MUX_ARB_RR_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire
